// File: rtl/arbiter_pkg.sv
// Shared state codes, default hold limit and state-to-grant decode for the
// three-requester grant controller.
package arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10,
        ST_G2   = 2'b11
    } state_t;

    localparam int unsigned MAX_HOLD_DEFAULT = 16;

    function automatic logic [2:0] state_to_gnt(input state_t s);
        logic [2:0] g;
        g = '0;
        case (s)
            ST_G0:   g = 3'b001;
            ST_G1:   g = 3'b010;
            ST_G2:   g = 3'b100;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arbiter_hold_timer.sv
// Counts cycles a grant has been held and flags the final permitted cycle.
module arbiter_hold_timer
    import arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int unsigned CW       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic busy,
    input  logic done_g,
    output logic hit
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;

    // Clear on every state load, count while a grant is held, saturate at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (load) begin
            hold_cnt <= '0;
        end else if (busy && (hold_cnt != LIMIT)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // A voluntary release in the last cycle takes precedence over the forced one.
    always_comb begin
        hit = busy && (hold_cnt == LIMIT) && !done_g;
    end

endmodule

// File: rtl/arbiter_grant_ctrl.sv
// Sequential side of the 3-requester arbiter: request sync/masking, state
// register loaded from the external next-state logic, grant decode and
// per-grant hold limit.
module arbiter_grant_ctrl
    import arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int unsigned CW       = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [2:0] REQ,
    input  logic [2:0] DONE,
    input  logic       Qp1,
    input  logic       Qp0,
    output logic       X2,
    output logic       X1,
    output logic       X0,
    output logic       Q1,
    output logic       Q0,
    output logic [2:0] GNT,
    output logic       BUSY,
    output logic       TIMEOUT
);

    state_t     q, q_next, cand;
    logic [2:0] req_r, mask, last_rel;
    logic [2:0] gnt, rel_mask, x;
    logic       done_g, hit, load, timeout_r;

    arbiter_hold_timer #(
        .MAX_HOLD(MAX_HOLD),
        .CW      (CW)
    ) u_hold_timer (
        .clk   (CLK),
        .rst_n (RESET_N),
        .load  (load),
        .busy  (|gnt),
        .done_g(done_g),
        .hit   (hit)
    );

    // Grant decode, release detection and the request vector offered to the next-state logic.
    always_comb begin
        gnt      = state_to_gnt(q);
        done_g   = |(gnt & DONE);
        rel_mask = gnt & (DONE | {3{hit}});
        x        = req_r & ~mask & ~rel_mask & ~last_rel;
        load     = (q == ST_IDLE) || done_g || hit;
    end

    // Next state: take the external code at arbitration points, but never grant an absent request.
    always_comb begin
        q_next = q;
        cand   = state_t'({Qp1, Qp0});
        if (load) begin
            if (|(state_to_gnt(cand) & ~x)) begin
                q_next = ST_IDLE;
            end else begin
                q_next = cand;
            end
        end
    end

    // State, request sync, timeout mask, one-cycle release mask and timeout pulse.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            q         <= ST_IDLE;
            req_r     <= '0;
            mask      <= '0;
            last_rel  <= '0;
            timeout_r <= 1'b0;
        end else begin
            q         <= q_next;
            req_r     <= REQ;
            mask      <= (mask & req_r) | (hit ? gnt : '0);
            last_rel  <= gnt & DONE;
            timeout_r <= hit;
        end
    end

    assign X2      = x[2];
    assign X1      = x[1];
    assign X0      = x[0];
    assign Q1      = q[1];
    assign Q0      = q[0];
    assign GNT     = gnt;
    assign BUSY    = |gnt;
    assign TIMEOUT = timeout_r;

endmodule

// File: tb/tb_arbiter_grant_ctrl.sv
// Directed bench for arbiter_grant_ctrl with a round-robin next-state stub.
module tb_arbiter_grant_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [2:0] REQ, DONE;
    logic       Qp1, Qp0;
    logic       X2, X1, X0, Q1, Q0, BUSY, TIMEOUT;
    logic [2:0] GNT;

    int compared   = 0;
    int mismatched = 0;

    logic       force_qp;
    logic [1:0] force_val;
    logic [1:0] stub_qp;
    logic [2:0] xv;
    logic [1:0] qv;
    int unsigned start, idx;
    logic        found;

    arbiter_grant_ctrl #(
        .MAX_HOLD(4),
        .CW      (8)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .REQ    (REQ),
        .DONE   (DONE),
        .Qp1    (Qp1),
        .Qp0    (Qp0),
        .X2     (X2),
        .X1     (X1),
        .X0     (X0),
        .Q1     (Q1),
        .Q0     (Q0),
        .GNT    (GNT),
        .BUSY   (BUSY),
        .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    assign xv = {X2, X1, X0};
    assign qv = {Q1, Q0};

    // Stub next-state logic: round robin starting after the current grant, or a forced code.
    always_comb begin
        stub_qp = 2'b00;
        found   = 1'b0;
        idx     = 0;
        start   = 32'(qv) % 3;
        if (force_qp) begin
            stub_qp = force_val;
        end else begin
            for (int k = 0; k < 3; k++) begin
                idx = (start + 32'(k)) % 3;
                if (!found && xv[idx]) begin
                    found   = 1'b1;
                    stub_qp = 2'(idx + 1);
                end
            end
        end
    end

    assign Qp1 = stub_qp[1];
    assign Qp0 = stub_qp[0];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N   = 1'b0;
        REQ       = '0;
        DONE      = '0;
        force_qp  = 1'b0;
        force_val = 2'b00;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N  = 1'b0;
        REQ      = 3'b111;
        DONE     = '0;
        force_qp = 1'b0;
        tick();
        tick();
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL reset_gnt got %b exp 000", GNT); end
        compared++; if (qv !== 2'b00) begin mismatched++; $display("FAIL reset_q got %b exp 00", qv); end
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL reset_x got %b exp 000", xv); end
        compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL reset_timeout got %b exp 0", TIMEOUT); end
        RESET_N = 1'b1;
        tick();
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL reset_rel1_gnt got %b exp 000", GNT); end
        tick();
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL reset_rel2_gnt got %b exp 001", GNT); end
        compared++; if (qv !== 2'b01) begin mismatched++; $display("FAIL reset_rel2_q got %b exp 01", qv); end
    endtask

    task automatic test_single_done();
        do_reset();
        REQ = 3'b010;
        tick();
        compared++; if (xv !== 3'b010) begin mismatched++; $display("FAIL single_x_latency got %b exp 010", xv); end
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL single_gnt_latency got %b exp 000", GNT); end
        for (int c = 0; c < 3; c++) begin
            tick();
            compared++; if (GNT !== 3'b010) begin mismatched++; $display("FAIL single_gnt_hold[%0d] got %b exp 010", c, GNT); end
        end
        compared++; if (BUSY !== 1'b1) begin mismatched++; $display("FAIL single_busy got %b exp 1", BUSY); end
        DONE = 3'b010;
        #1;
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL single_x_done_cycle got %b exp 000", xv); end
        tick();
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL single_gnt_after_done got %b exp 000", GNT); end
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL single_x_last_rel got %b exp 000", xv); end
        compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL single_timeout got %b exp 0", TIMEOUT); end
        DONE = '0;
        REQ  = '0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] g [0:2];
        logic [2:0] expx;
        g[0] = 3'b001; g[1] = 3'b010; g[2] = 3'b100;
        do_reset();
        REQ = 3'b111;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            DONE = '0;
            compared++; if (GNT !== g[k]) begin mismatched++; $display("FAIL b2b_first[%0d] got %b exp %b", k, GNT, g[k]); end
            expx = (k == 0) ? 3'b111 : (3'b111 & ~g[k-1]);
            #1;
            compared++; if (xv !== expx) begin mismatched++; $display("FAIL b2b_x[%0d] got %b exp %b", k, xv, expx); end
            tick();
            compared++; if (GNT !== g[k]) begin mismatched++; $display("FAIL b2b_second[%0d] got %b exp %b", k, GNT, g[k]); end
            DONE = g[k];
        end
        tick();
        DONE = '0;
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL b2b_wrap got %b exp 001", GNT); end
        REQ = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        REQ = 3'b001;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL to_gnt_hold[%0d] got %b exp 001", c, GNT); end
            compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL to_early_pulse[%0d] got %b exp 0", c, TIMEOUT); end
        end
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL to_x_hit_cycle got %b exp 000", xv); end
        tick();
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL to_gnt_release got %b exp 000", GNT); end
        compared++; if (TIMEOUT !== 1'b1) begin mismatched++; $display("FAIL to_pulse got %b exp 1", TIMEOUT); end
        tick();
        compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL to_pulse_width got %b exp 0", TIMEOUT); end
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL to_mask1 got %b exp 000", xv); end
        tick();
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL to_mask2 got %b exp 000", xv); end
        REQ = 3'b000;
        tick();
        REQ = 3'b001;
        tick();
        compared++; if (xv !== 3'b001) begin mismatched++; $display("FAIL to_unmask got %b exp 001", xv); end
        tick();
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL to_regrant got %b exp 001", GNT); end
        REQ = '0;
    endtask

    task automatic test_done_corner();
        do_reset();
        REQ = 3'b001;
        tick();
        tick();
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL dc_gnt got %b exp 001", GNT); end
        DONE = 3'b100;
        tick();
        DONE = '0;
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL dc_foreign_done got %b exp 001", GNT); end
        #1;
        compared++; if (xv !== 3'b001) begin mismatched++; $display("FAIL dc_foreign_x got %b exp 001", xv); end
        tick();
        tick();
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL dc_gnt_last got %b exp 001", GNT); end
        DONE = 3'b001;
        #1;
        compared++; if (xv !== 3'b000) begin mismatched++; $display("FAIL dc_x_release got %b exp 000", xv); end
        tick();
        DONE = '0;
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL dc_gnt_release got %b exp 000", GNT); end
        compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL dc_no_timeout got %b exp 0", TIMEOUT); end
        tick();
        compared++; if (xv !== 3'b001) begin mismatched++; $display("FAIL dc_no_mask got %b exp 001", xv); end
        compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL dc_no_timeout2 got %b exp 0", TIMEOUT); end
        REQ = '0;
    endtask

    task automatic test_illegal_qp();
        do_reset();
        REQ       = 3'b001;
        force_qp  = 1'b1;
        force_val = 2'b11;
        tick();
        tick();
        compared++; if (qv !== 2'b00) begin mismatched++; $display("FAIL illegal_q got %b exp 00", qv); end
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL illegal_gnt got %b exp 000", GNT); end
        tick();
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL illegal_gnt2 got %b exp 000", GNT); end
        force_qp = 1'b0;
        tick();
        compared++; if (GNT !== 3'b001) begin mismatched++; $display("FAIL illegal_recover got %b exp 001", GNT); end
        RESET_N = 1'b0;
        tick();
        compared++; if (GNT !== 3'b000) begin mismatched++; $display("FAIL midreset_gnt got %b exp 000", GNT); end
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL midreset_busy got %b exp 0", BUSY); end
        compared++; if (TIMEOUT !== 1'b0) begin mismatched++; $display("FAIL midreset_timeout got %b exp 0", TIMEOUT); end
        RESET_N = 1'b1;
        REQ     = '0;
    endtask

    initial begin
        RESET_N   = 1'b0;
        REQ       = '0;
        DONE      = '0;
        force_qp  = 1'b0;
        force_val = 2'b00;
        test_reset();
        test_single_done();
        test_back_to_back();
        test_timeout();
        test_done_corner();
        test_illegal_qp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
